// File: rtl/ct_spsram_param_init.sv
// Parametrised single-port SRAM with per-bit write mask, 1/2-cycle read latency,
// post-reset zero-fill sweep and out-of-range address handling.
module ct_spsram_param_init #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned INIT_EN    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  QVLD,
    output logic                  RDY
);

    localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("ct_spsram_param_init: RD_LAT must be 1 or 2");
    end
    if (DEPTH < 2 || 64'(DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("ct_spsram_param_init: DEPTH must be in 2..2**ADDR_WIDTH");
    end

    typedef enum logic [1:0] {StInit, StIdle, StReady} state_e;
    localparam state_e RST_STATE = (INIT_EN != 0) ? StInit : StIdle;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  init_we;
    logic                  in_range;
    logic                  acc, wr_en, rd_acc;
    logic [IDXW-1:0]       idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  pipe_vld;
    logic [DATA_WIDTH-1:0] pipe_data;
    logic [DATA_WIDTH-1:0] q_q;
    logic                  qvld_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The range compare only exists when the address space is larger than the array.
    if (64'(DEPTH) < (64'd1 << ADDR_WIDTH)) begin : g_range
        localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
        assign in_range = ({1'b0, A} < DEPTH_W);
    end else begin : g_full
        assign in_range = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        unique case (state_q)
            StInit: begin
                init_we = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = StReady;
                end
            end
            StIdle:  state_d = StReady;
            StReady: state_d = StReady;
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign RDY    = (state_q == StReady);
    assign idx    = A[IDXW-1:0];
    assign acc    = RDY && !CEN && !RST;
    assign wr_en  = acc && !GWEN && in_range;
    assign rd_acc = acc && GWEN;

    always_ff @(posedge CLK) begin
        if (init_we && !RST) begin
            mem[cnt_q[IDXW-1:0]] <= '0;
        end else if (wr_en) begin
            mem[idx] <= (mem[idx] & WEN) | (D & ~WEN);
        end
    end

    assign rd_data = in_range ? mem[idx] : '0;

    if (RD_LAT == 2) begin : g_lat2
        logic                  v1_q;
        logic [DATA_WIDTH-1:0] d1_q;

        always_ff @(posedge CLK) begin
            if (RST) begin
                v1_q <= 1'b0;
                d1_q <= '0;
            end else begin
                v1_q <= rd_acc;
                if (rd_acc) begin
                    d1_q <= rd_data;
                end
            end
        end

        assign pipe_vld  = v1_q;
        assign pipe_data = d1_q;
    end else begin : g_lat1
        assign pipe_vld  = rd_acc;
        assign pipe_data = rd_data;
    end

    // Q only moves when a read result lands; otherwise it holds the last value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q    <= '0;
            qvld_q <= 1'b0;
        end else begin
            qvld_q <= pipe_vld;
            if (pipe_vld) begin
                q_q <= pipe_data;
            end
        end
    end

    assign Q    = q_q;
    assign QVLD = qvld_q;

endmodule

// File: tb/tb_ct_spsram_param_init.sv
// Directed bench: three instances (sweep/RD_LAT=1, RD_LAT=2 with out-of-range, no sweep)
// sharing address/data inputs, each with its own reset and chip enable.
module tb_ct_spsram_param_init;

    localparam logic [127:0] ONES   = '1;
    localparam logic [127:0] MASKED = ~128'hFF00;

    logic         clk = 1'b0;
    logic [2:0]   rst;
    logic [2:0]   cen;
    logic         gwen;
    logic [4:0]   a;
    logic [127:0] wen;
    logic [127:0] d;
    logic [127:0] q [3];
    logic [2:0]   qvld;
    logic [2:0]   rdy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ct_spsram_param_init #(
        .ADDR_WIDTH(4), .DATA_WIDTH(128), .DEPTH(16), .RD_LAT(1), .INIT_EN(1)
    ) u0 (
        .CLK(clk), .RST(rst[0]), .A(a[3:0]), .CEN(cen[0]), .GWEN(gwen), .WEN(wen), .D(d),
        .Q(q[0]), .QVLD(qvld[0]), .RDY(rdy[0])
    );

    ct_spsram_param_init #(
        .ADDR_WIDTH(5), .DATA_WIDTH(128), .DEPTH(20), .RD_LAT(2), .INIT_EN(1)
    ) u1 (
        .CLK(clk), .RST(rst[1]), .A(a), .CEN(cen[1]), .GWEN(gwen), .WEN(wen), .D(d),
        .Q(q[1]), .QVLD(qvld[1]), .RDY(rdy[1])
    );

    ct_spsram_param_init #(
        .ADDR_WIDTH(4), .DATA_WIDTH(128), .DEPTH(16), .RD_LAT(1), .INIT_EN(0)
    ) u2 (
        .CLK(clk), .RST(rst[2]), .A(a[3:0]), .CEN(cen[2]), .GWEN(gwen), .WEN(wen), .D(d),
        .Q(q[2]), .QVLD(qvld[2]), .RDY(rdy[2])
    );

    typedef struct {
        logic         wr;
        logic         ce;
        logic [4:0]   addr;
        logic [127:0] wmask;
        logic [127:0] data;
        logic         exp_vld;
        logic [127:0] exp_q;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int u, input logic wr, input logic [4:0] aa,
                      input logic [127:0] ww, input logic [127:0] dd);
        cen  = ~(3'b001 << u);
        gwen = ~wr;
        a    = aa;
        wen  = ww;
        d    = dd;
        step();
        cen  = '1;
    endtask

    task automatic idle();
        cen = '1;
        step();
    endtask

    initial begin
        int lat [3];
        int n;

        tbl[0]  = '{1'b1, 1'b1, 5'd5,  '0,     ONES,                1'b0, '0};
        tbl[1]  = '{1'b1, 1'b1, 5'd5,  MASKED, '0,                  1'b0, '0};
        tbl[2]  = '{1'b0, 1'b1, 5'd5,  ONES,   '0,                  1'b1, MASKED};
        tbl[3]  = '{1'b0, 1'b0, 5'd5,  ONES,   '0,                  1'b0, MASKED};
        tbl[4]  = '{1'b1, 1'b1, 5'd7,  ONES,   ONES,                1'b0, MASKED};
        tbl[5]  = '{1'b0, 1'b1, 5'd7,  ONES,   '0,                  1'b1, '0};
        tbl[6]  = '{1'b1, 1'b1, 5'd0,  '0,     128'h1234_5678,      1'b0, '0};
        tbl[7]  = '{1'b0, 1'b1, 5'd0,  '0,     ONES,                1'b1, 128'h1234_5678};
        tbl[8]  = '{1'b0, 1'b1, 5'd15, ONES,   '0,                  1'b1, '0};
        tbl[9]  = '{1'b0, 1'b1, 5'd5,  ONES,   '0,                  1'b1, MASKED};
        tbl[10] = '{1'b0, 1'b0, 5'd5,  ONES,   '0,                  1'b0, MASKED};

        rst  = '1;
        cen  = '1;
        gwen = 1'b1;
        a    = '0;
        wen  = '1;
        d    = '0;
        step();
        step();
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("reset_rdy%0d", u), 128'(rdy[u]), '0);
            chk($sformatf("reset_qvld%0d", u), 128'(qvld[u]), '0);
            chk($sformatf("reset_q%0d", u), q[u], '0);
        end

        // Release reset; u0 gets a write attempt while still sweeping.
        rst  = '0;
        lat  = '{0, 0, 0};
        cen  = 3'b110;
        gwen = 1'b0;
        a    = 5'd3;
        wen  = '0;
        d    = ONES;
        for (n = 1; n <= 100; n++) begin
            step();
            if (n == 4) cen = '1;
            for (int u = 0; u < 3; u++) begin
                if (lat[u] == 0 && rdy[u]) lat[u] = n;
            end
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
        end
        cen = '1;
        chk("init_lat_u0", 128'(lat[0]), 128'd16);
        chk("init_lat_u1", 128'(lat[1]), 128'd20);
        chk("init_lat_u2", 128'(lat[2]), 128'd1);

        for (int i = 0; i < 16; i++) begin
            op(0, 1'b0, 5'(i), ONES, '0);
            chk($sformatf("sweep_q_a%0d", i), q[0], '0);
            chk($sformatf("sweep_vld_a%0d", i), 128'(qvld[0]), 128'd1);
        end

        for (int i = 0; i < 11; i++) begin
            cen  = tbl[i].ce ? 3'b110 : 3'b111;
            gwen = ~tbl[i].wr;
            a    = tbl[i].addr;
            wen  = tbl[i].wmask;
            d    = tbl[i].data;
            step();
            chk($sformatf("vec%0d_q", i), q[0], tbl[i].exp_q);
            chk($sformatf("vec%0d_vld", i), 128'(qvld[0]), 128'(tbl[i].exp_vld));
        end
        cen = '1;

        // RD_LAT=2 pipelining.
        op(1, 1'b1, 5'd1, '0, {16{8'hAA}});
        op(1, 1'b1, 5'd2, '0, {16{8'h55}});
        op(1, 1'b0, 5'd1, ONES, '0);
        chk("lat2_vld_t0", 128'(qvld[1]), '0);
        op(1, 1'b0, 5'd2, ONES, '0);
        chk("lat2_vld_t1", 128'(qvld[1]), 128'd1);
        chk("lat2_q_t1", q[1], {16{8'hAA}});
        idle();
        chk("lat2_vld_t2", 128'(qvld[1]), 128'd1);
        chk("lat2_q_t2", q[1], {16{8'h55}});
        idle();
        chk("lat2_vld_t3", 128'(qvld[1]), '0);
        chk("lat2_q_hold", q[1], {16{8'h55}});

        op(1, 1'b1, 5'd3, '0, 128'h1234);
        op(1, 1'b0, 5'd3, ONES, '0);
        idle();
        chk("raw_q", q[1], 128'h1234);
        chk("raw_vld", 128'(qvld[1]), 128'd1);

        op(1, 1'b1, 5'd5, '0, 128'h5555);
        op(1, 1'b1, 5'd25, '0, 128'hFFFF);
        op(1, 1'b0, 5'd25, ONES, '0);
        idle();
        chk("oor_q", q[1], '0);
        chk("oor_vld", 128'(qvld[1]), 128'd1);
        op(1, 1'b0, 5'd5, ONES, '0);
        idle();
        chk("oor_alias_q", q[1], 128'h5555);

        // Reset lands while a RD_LAT=2 read is in flight.
        op(1, 1'b0, 5'd3, ONES, '0);
        rst[1] = 1'b1;
        idle();
        chk("kill_vld0", 128'(qvld[1]), '0);
        chk("kill_q0", q[1], '0);
        chk("kill_rdy", 128'(rdy[1]), '0);
        rst[1] = 1'b0;
        idle();
        chk("kill_vld1", 128'(qvld[1]), '0);
        chk("kill_q1", q[1], '0);

        // No-sweep instance, and a write on a reset edge.
        op(2, 1'b1, 5'd0, '0, 128'hDEAD);
        op(2, 1'b0, 5'd0, ONES, '0);
        chk("noinit_q", q[2], 128'hDEAD);
        chk("noinit_vld", 128'(qvld[2]), 128'd1);
        op(2, 1'b1, 5'd1, '0, 128'h1111);
        rst[2] = 1'b1;
        op(2, 1'b1, 5'd1, '0, 128'hBEEF);
        rst[2] = 1'b0;
        idle();
        chk("noinit_rdy_after_rst", 128'(rdy[2]), 128'd1);
        op(2, 1'b0, 5'd1, ONES, '0);
        chk("rst_write_dropped", q[2], 128'h1111);

        // Reset part-way through the sweep restarts it from word 0.
        rst[0] = 1'b1;
        idle();
        rst[0] = 1'b0;
        for (int i = 0; i < 7; i++) idle();
        rst[0] = 1'b1;
        idle();
        chk("midinit_rdy", 128'(rdy[0]), '0);
        rst[0] = 1'b0;
        lat[0] = 0;
        for (n = 1; n <= 100; n++) begin
            step();
            if (rdy[0]) begin
                lat[0] = n;
                break;
            end
        end
        chk("midinit_lat", 128'(lat[0]), 128'd16);
        op(0, 1'b0, 5'd5, ONES, '0);
        chk("resweep_a5", q[0], '0);
        op(0, 1'b0, 5'd7, ONES, '0);
        op(0, 1'b0, 5'd0, ONES, '0);
        chk("resweep_a0", q[0], '0);
        chk("resweep_vld", 128'(qvld[0]), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
